// File: rtl/sc_frog_pkg.sv
// rtl/sc_frog_pkg.sv - shared state encoding, shift codes and helpers for the frog controller
package sc_frog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_PLAY     = 3'd2,
    ST_DEAD     = 3'd3,
    ST_NEST     = 3'd4,
    ST_RESPAWN  = 3'd5,
    ST_GAMEOVER = 3'd6
  } state_e;

  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/sc_edge_detect_low.sv
// rtl/sc_edge_detect_low.sv - one-cycle press pulse on a 1->0 transition of an active-low button
module sc_edge_detect_low
  import sc_frog_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic press_o
);

  logic btn_q;

  // Idle level is high so a clean reset never manufactures a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) btn_q <= 1'b1;
    else         btn_q <= btn_ni;
  end

  assign press_o = btn_q & ~btn_ni;

endmodule

// File: rtl/sc_frog_ctrl_fsm.sv
// rtl/sc_frog_ctrl_fsm.sv - game controller issuing single-cycle commands to the frog register
module sc_frog_ctrl_fsm
  import sc_frog_pkg::*;
#(
  parameter int unsigned       COL_W       = 3,
  parameter int unsigned       ROW_W       = 4,
  parameter logic [ROW_W-1:0]  ROW_TOP     = 4'd11,
  parameter logic [COL_W-1:0]  COL_INIT    = 3'd3,
  parameter logic [1:0]        LIVES_INIT  = 2'd3,
  parameter logic [2:0]        NESTS_TOTAL = 3'd5,
  parameter logic [7:0]        HOLD_CYCLES = 8'd50
) (
  input  logic             SC_FrogCtrl_CLOCK_50,
  input  logic             SC_FrogCtrl_RESET_InLow,
  input  logic             SC_FrogCtrl_start_InLow,
  input  logic             SC_FrogCtrl_left_InLow,
  input  logic             SC_FrogCtrl_right_InLow,
  input  logic             SC_FrogCtrl_up_InLow,
  input  logic             SC_FrogCtrl_down_InLow,
  input  logic             SC_FrogCtrl_collision_InLow,
  input  logic             SC_FrogCtrl_nest_InLow,
  output logic             SC_FrogCtrl_clear_OutLow,
  output logic             SC_FrogCtrl_load0_OutLow,
  output logic             SC_FrogCtrl_load1_OutLow,
  output logic [1:0]       SC_FrogCtrl_shiftselection_Out,
  output logic [ROW_W-1:0] SC_FrogCtrl_row_OutBUS,
  output logic [COL_W-1:0] SC_FrogCtrl_col_OutBUS,
  output logic [1:0]       SC_FrogCtrl_lives_OutBUS,
  output logic [2:0]       SC_FrogCtrl_nests_OutBUS,
  output logic             SC_FrogCtrl_gameover_OutHigh,
  output logic             SC_FrogCtrl_win_OutHigh
);

  localparam logic [COL_W-1:0] COL_MAX = {COL_W{1'b1}};

  logic clk, rst_n;
  assign clk   = SC_FrogCtrl_CLOCK_50;
  assign rst_n = SC_FrogCtrl_RESET_InLow;

  logic start_p, left_p, right_p, up_p, down_p;

  sc_edge_detect_low u_ed_start (.clk_i(clk), .rst_ni(rst_n), .btn_ni(SC_FrogCtrl_start_InLow), .press_o(start_p));
  sc_edge_detect_low u_ed_left  (.clk_i(clk), .rst_ni(rst_n), .btn_ni(SC_FrogCtrl_left_InLow),  .press_o(left_p));
  sc_edge_detect_low u_ed_right (.clk_i(clk), .rst_ni(rst_n), .btn_ni(SC_FrogCtrl_right_InLow), .press_o(right_p));
  sc_edge_detect_low u_ed_up    (.clk_i(clk), .rst_ni(rst_n), .btn_ni(SC_FrogCtrl_up_InLow),    .press_o(up_p));
  sc_edge_detect_low u_ed_down  (.clk_i(clk), .rst_ni(rst_n), .btn_ni(SC_FrogCtrl_down_InLow),  .press_o(down_p));

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       lives_q, lives_d;
  logic [2:0]       nests_q, nests_d;
  logic [7:0]       hold_q, hold_d;
  logic             clear_q, clear_d, load0_q, load0_d, load1_q, load1_d;
  logic [1:0]       shift_q, shift_d;
  logic             gameover_q, gameover_d, win_q, win_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    lives_d    = lives_q;
    nests_d    = nests_q;
    hold_d     = hold_q;
    clear_d    = 1'b1;
    load0_d    = 1'b1;
    load1_d    = 1'b1;
    shift_d    = SHIFT_HOLD;
    gameover_d = gameover_q;
    win_d      = win_q;

    case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_p) begin
          state_d    = ST_INIT;
          clear_d    = 1'b0;
          lives_d    = LIVES_INIT;
          nests_d    = 3'd0;
          row_d      = '0;
          col_d      = COL_INIT;
          gameover_d = 1'b0;
          win_d      = 1'b0;
        end
      end
      ST_INIT, ST_RESPAWN: state_d = ST_PLAY;
      ST_PLAY: begin
        // Only the highest-priority event or press is served; the rest are dropped.
        if (!SC_FrogCtrl_collision_InLow) begin
          state_d = ST_DEAD;
          lives_d = sat_dec2(lives_q);
          hold_d  = 8'd0;
        end else if (!SC_FrogCtrl_nest_InLow) begin
          state_d = ST_NEST;
          nests_d = (nests_q < NESTS_TOTAL) ? nests_q + 3'd1 : nests_q;
          hold_d  = 8'd0;
        end else if (up_p) begin
          if (row_q < ROW_TOP) begin
            load0_d = 1'b0;
            row_d   = row_q + 1'b1;
          end
        end else if (down_p) begin
          if (row_q != '0) begin
            load1_d = 1'b0;
            row_d   = row_q - 1'b1;
          end
        end else if (left_p) begin
          if (col_q != COL_MAX) begin
            shift_d = SHIFT_LEFT;
            col_d   = col_q + 1'b1;
          end
        end else if (right_p) begin
          if (col_q != '0) begin
            shift_d = SHIFT_RIGHT;
            col_d   = col_q - 1'b1;
          end
        end
      end
      ST_DEAD, ST_NEST: begin
        if (hold_q == HOLD_CYCLES - 8'd1) begin
          if (state_q == ST_DEAD && lives_q == 2'd0) begin
            state_d    = ST_GAMEOVER;
            gameover_d = 1'b1;
          end else if (state_q == ST_NEST && nests_q == NESTS_TOTAL) begin
            state_d    = ST_GAMEOVER;
            gameover_d = 1'b1;
            win_d      = 1'b1;
          end else begin
            state_d = ST_RESPAWN;
            clear_d = 1'b0;
            row_d   = '0;
            col_d   = COL_INIT;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= COL_INIT;
      lives_q    <= 2'd0;
      nests_q    <= 3'd0;
      hold_q     <= 8'd0;
      clear_q    <= 1'b1;
      load0_q    <= 1'b1;
      load1_q    <= 1'b1;
      shift_q    <= SHIFT_HOLD;
      gameover_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      lives_q    <= lives_d;
      nests_q    <= nests_d;
      hold_q     <= hold_d;
      clear_q    <= clear_d;
      load0_q    <= load0_d;
      load1_q    <= load1_d;
      shift_q    <= shift_d;
      gameover_q <= gameover_d;
      win_q      <= win_d;
    end
  end

  assign SC_FrogCtrl_clear_OutLow       = clear_q;
  assign SC_FrogCtrl_load0_OutLow       = load0_q;
  assign SC_FrogCtrl_load1_OutLow       = load1_q;
  assign SC_FrogCtrl_shiftselection_Out = shift_q;
  assign SC_FrogCtrl_row_OutBUS         = row_q;
  assign SC_FrogCtrl_col_OutBUS         = col_q;
  assign SC_FrogCtrl_lives_OutBUS       = lives_q;
  assign SC_FrogCtrl_nests_OutBUS       = nests_q;
  assign SC_FrogCtrl_gameover_OutHigh   = gameover_q;
  assign SC_FrogCtrl_win_OutHigh        = win_q;

endmodule

// File: tb/tb_sc_frog_ctrl_fsm.sv
// tb/tb_sc_frog_ctrl_fsm.sv - directed table-driven bench for the frog game controller
module tb_sc_frog_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_n, left_n, right_n, up_n, down_n, coll_n, nest_n;
  logic clr_n, ld0_n, ld1_n, go, win;
  logic [1:0] shs, lives;
  logic [3:0] row;
  logic [2:0] col, nests;

  sc_frog_ctrl_fsm dut (
    .SC_FrogCtrl_CLOCK_50(clk),
    .SC_FrogCtrl_RESET_InLow(rst_n),
    .SC_FrogCtrl_start_InLow(start_n),
    .SC_FrogCtrl_left_InLow(left_n),
    .SC_FrogCtrl_right_InLow(right_n),
    .SC_FrogCtrl_up_InLow(up_n),
    .SC_FrogCtrl_down_InLow(down_n),
    .SC_FrogCtrl_collision_InLow(coll_n),
    .SC_FrogCtrl_nest_InLow(nest_n),
    .SC_FrogCtrl_clear_OutLow(clr_n),
    .SC_FrogCtrl_load0_OutLow(ld0_n),
    .SC_FrogCtrl_load1_OutLow(ld1_n),
    .SC_FrogCtrl_shiftselection_Out(shs),
    .SC_FrogCtrl_row_OutBUS(row),
    .SC_FrogCtrl_col_OutBUS(col),
    .SC_FrogCtrl_lives_OutBUS(lives),
    .SC_FrogCtrl_nests_OutBUS(nests),
    .SC_FrogCtrl_gameover_OutHigh(go),
    .SC_FrogCtrl_win_OutHigh(win)
  );

  int checks = 0;
  int failures = 0;

  // Active cycles of each command, sampled on the falling edge.
  int n_clr = 0, n_ld0 = 0, n_ld1 = 0, n_shl = 0, n_shr = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!clr_n) n_clr++;
      if (!ld0_n) n_ld0++;
      if (!ld1_n) n_ld1++;
      if (shs == 2'b01) n_shl++;
      if (shs == 2'b10) n_shr++;
    end
  end

  int b_clr, b_ld0, b_ld1, b_shl, b_shr;
  task automatic snap();
    b_clr = n_clr; b_ld0 = n_ld0; b_ld1 = n_ld1; b_shl = n_shl; b_shr = n_shr;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // m: {up, down, left, right}
  task automatic press(input logic [3:0] m, input int hold);
    @(negedge clk);
    up_n = ~m[3]; down_n = ~m[2]; left_n = ~m[1]; right_n = ~m[0];
    repeat (hold) @(negedge clk);
    up_n = 1'b1; down_n = 1'b1; left_n = 1'b1; right_n = 1'b1;
  endtask

  task automatic start_game();
    snap();
    @(negedge clk); start_n = 1'b0;
    repeat (2) @(negedge clk); start_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_clear_cycles", n_clr - b_clr, 1);
    chk("start_lives", lives, 3);
    chk("start_nests", nests, 0);
    chk("start_row", row, 0);
    chk("start_col", col, 3);
    chk("start_gameover", go, 0);
    chk("start_win", win, 0);
  endtask

  task automatic pulse_event(input bit is_nest);
    @(negedge clk);
    if (is_nest) nest_n = 1'b0; else coll_n = 1'b0;
    @(negedge clk);
    nest_n = 1'b1; coll_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clear"}, clr_n, 1);
    chk({tag, "_load0"}, ld0_n, 1);
    chk({tag, "_load1"}, ld1_n, 1);
    chk({tag, "_shift"}, shs, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_col"}, col, 3);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_nests"}, nests, 0);
    chk({tag, "_gameover"}, go, 0);
    chk({tag, "_win"}, win, 0);
  endtask

  typedef struct {
    logic [3:0] btn;
    int hold;
    int e_row, e_col, e_ld0, e_ld1, e_shl, e_shr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'b0010, 10, 0, 4, 0, 0, 1, 0};
    tbl[1]  = '{4'b0010, 1,  0, 5, 0, 0, 1, 0};
    tbl[2]  = '{4'b0010, 1,  0, 6, 0, 0, 1, 0};
    tbl[3]  = '{4'b0010, 1,  0, 7, 0, 0, 1, 0};
    tbl[4]  = '{4'b0010, 1,  0, 7, 0, 0, 0, 0};
    tbl[5]  = '{4'b1010, 1,  1, 7, 1, 0, 0, 0};
    tbl[6]  = '{4'b0100, 1,  0, 7, 0, 1, 0, 0};
    tbl[7]  = '{4'b0100, 1,  0, 7, 0, 0, 0, 0};
    tbl[8]  = '{4'b0001, 1,  0, 6, 0, 0, 0, 1};
    tbl[9]  = '{4'b0011, 1,  0, 7, 0, 0, 1, 0};
    tbl[10] = '{4'b1100, 1,  1, 7, 1, 0, 0, 0};
    tbl[11] = '{4'b0101, 1,  0, 7, 0, 1, 0, 0};

    rst_n = 1'b0; start_n = 1'b1; left_n = 1'b1; right_n = 1'b1;
    up_n = 1'b1; down_n = 1'b1; coll_n = 1'b1; nest_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("post_rst");

    start_game();

    for (int i = 0; i < 12; i++) begin
      snap();
      press(tbl[i].btn, tbl[i].hold);
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_row", i), row, tbl[i].e_row);
      chk($sformatf("v%0d_col", i), col, tbl[i].e_col);
      chk($sformatf("v%0d_load0", i), n_ld0 - b_ld0, tbl[i].e_ld0);
      chk($sformatf("v%0d_load1", i), n_ld1 - b_ld1, tbl[i].e_ld1);
      chk($sformatf("v%0d_shl", i), n_shl - b_shl, tbl[i].e_shl);
      chk($sformatf("v%0d_shr", i), n_shr - b_shr, tbl[i].e_shr);
    end

    snap();
    for (int i = 0; i < 11; i++) press(4'b1000, 1);
    repeat (2) @(negedge clk);
    chk("climb_row", row, 11);
    chk("climb_load0", n_ld0 - b_ld0, 11);
    snap();
    press(4'b1000, 1);
    repeat (2) @(negedge clk);
    chk("top_row", row, 11);
    chk("top_load0", n_ld0 - b_ld0, 0);

    snap();
    for (int k = 0; k < 3; k++) begin
      pulse_event(1'b0);
      chk($sformatf("death%0d_lives", k), lives, 2 - k);
      press(4'b1010, 1);
      repeat (60) @(negedge clk);
    end
    chk("deaths_clear", n_clr - b_clr, 2);
    chk("deaths_ld0", n_ld0 - b_ld0, 0);
    chk("deaths_shl", n_shl - b_shl, 0);
    chk("deaths_gameover", go, 1);
    chk("deaths_win", win, 0);
    chk("deaths_row", row, 0);
    chk("deaths_col", col, 3);

    start_game();
    snap();
    for (int k = 0; k < 5; k++) begin
      pulse_event(1'b1);
      chk($sformatf("nest%0d_count", k), nests, k + 1);
      repeat (60) @(negedge clk);
    end
    chk("nests_clear", n_clr - b_clr, 4);
    chk("nests_gameover", go, 1);
    chk("nests_win", win, 1);
    chk("nests_lives", lives, 3);

    start_game();
    pulse_event(1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midhold");
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (3) @(negedge clk);
    press(4'b0010, 1);
    repeat (60) @(negedge clk);
    chk("idle_clear", n_clr - b_clr, 0);
    chk("idle_shl", n_shl - b_shl, 0);
    chk("idle_col", col, 3);
    chk("idle_gameover", go, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
